// File: rtl/cia_bus_initiator_pkg.sv
// Shared types and constants for the CIA bus initiator and its E-clock generator.
package cia_bus_pkg;

  localparam int E_LOW_DEF  = 6;
  localparam int E_HIGH_DEF = 4;

  localparam int CIAB_LANE = 1;
  localparam int CIAA_LANE = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_DONE    = 3'd3,
    ST_RELEASE = 3'd4
  } cia_state_e;

  typedef struct packed {
    cia_state_e state;
    logic [3:0] ecnt;
  } cia_dbg_t;

endpackage

// File: rtl/cia_bus_initiator_if.sv
// CPU-side request port and CIA-side strobe/data bus of the initiator.
// Handshake is four-phase: cpu_req rises, cpu_ack pulses one clk7_en period, cpu_req must fall before the next request.
interface cia_bus_if;
  logic        cpu_req;
  logic        cpu_rnw;
  logic [1:0]  cpu_sel;
  logic [3:0]  cpu_rs;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        cpu_ack;
  logic        eclk;
  logic [3:0]  cia_rs;
  logic        cia_rd;
  logic        cia_wr;
  logic        ciaa_aen;
  logic        ciab_aen;
  logic [7:0]  ciaa_wdata;
  logic [7:0]  ciab_wdata;
  logic [7:0]  ciaa_rdata;
  logic [7:0]  ciab_rdata;

  modport master (
    input  cpu_req, cpu_rnw, cpu_sel, cpu_rs, cpu_din, ciaa_rdata, ciab_rdata,
    output cpu_dout, cpu_ack, eclk, cia_rs, cia_rd, cia_wr,
           ciaa_aen, ciab_aen, ciaa_wdata, ciab_wdata
  );

  modport slave (
    output cpu_req, cpu_rnw, cpu_sel, cpu_rs, cpu_din, ciaa_rdata, ciab_rdata,
    input  cpu_dout, cpu_ack, eclk, cia_rs, cia_rd, cia_wr,
           ciaa_aen, ciab_aen, ciaa_wdata, ciab_wdata
  );
endinterface

// File: rtl/cia_eclk_gen.sv
// Free-running E-clock generator: phase counter, registered E clock and phase decodes.
module cia_eclk_gen
  import cia_bus_pkg::*;
#(
  parameter int E_LOW  = E_LOW_DEF,
  parameter int E_HIGH = E_HIGH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk7_en,
  output logic [3:0] ecnt,
  output logic       eclk,
  output logic       phase_sync,
  output logic       phase_strobe,
  output logic       phase_last
);

  localparam logic [3:0] CNT_LAST   = 4'(E_LOW + E_HIGH - 1);
  localparam logic [3:0] CNT_STROBE = 4'(E_LOW + E_HIGH - 2);
  localparam logic [3:0] CNT_SYNC   = 4'(E_LOW - 1);
  localparam logic [3:0] CNT_HIGH   = 4'(E_LOW);

  logic [3:0] ecnt_nxt;

  always_comb begin
    ecnt_nxt = (ecnt == CNT_LAST) ? 4'd0 : ecnt + 4'd1;
  end

  // eclk is derived from the next count so it stays aligned with ecnt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ecnt <= 4'd0;
      eclk <= 1'b0;
    end else if (clk7_en) begin
      ecnt <= ecnt_nxt;
      eclk <= (ecnt_nxt >= CNT_HIGH);
    end
  end

  assign phase_sync   = (ecnt == CNT_SYNC);
  assign phase_strobe = (ecnt == CNT_STROBE);
  assign phase_last   = (ecnt == CNT_LAST);

endmodule

// File: rtl/cia_bus_initiator.sv
// Turns a CPU request into one E-aligned 6800-style access on CIA-A and/or CIA-B.
module cia_bus_initiator
  import cia_bus_pkg::*;
#(
  parameter int E_LOW  = E_LOW_DEF,
  parameter int E_HIGH = E_HIGH_DEF
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      clk7_en,
  cia_bus_if.master bus,
  output cia_dbg_t  dbg
);

  cia_state_e  state, state_n;
  logic        rnw_q, rnw_n;
  logic [1:0]  sel_q, sel_n;
  logic [3:0]  rs_q, rs_n;
  logic [7:0]  wa_q, wa_n, wb_q, wb_n;
  logic        aen_a_q, aen_a_n, aen_b_q, aen_b_n;
  logic        rd_q, rd_n, wr_q, wr_n;
  logic        ack_q, ack_n;
  logic [15:0] dout_q, dout_n;

  logic [3:0] ecnt;
  logic       eclk, phase_sync, phase_strobe, phase_last;

  cia_eclk_gen #(.E_LOW(E_LOW), .E_HIGH(E_HIGH)) u_eclk (
    .clk          (clk),
    .reset        (reset),
    .clk7_en      (clk7_en),
    .ecnt         (ecnt),
    .eclk         (eclk),
    .phase_sync   (phase_sync),
    .phase_strobe (phase_strobe),
    .phase_last   (phase_last)
  );

  always_comb begin
    state_n = state;
    rnw_n   = rnw_q;
    sel_n   = sel_q;
    rs_n    = rs_q;
    wa_n    = wa_q;
    wb_n    = wb_q;
    aen_a_n = aen_a_q;
    aen_b_n = aen_b_q;
    rd_n    = rd_q;
    wr_n    = wr_q;
    ack_n   = ack_q;
    dout_n  = dout_q;
    unique case (state)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          rnw_n   = bus.cpu_rnw;
          sel_n   = bus.cpu_sel;
          rs_n    = bus.cpu_rs;
          wa_n    = bus.cpu_din[CIAA_LANE*8 +: 8];
          wb_n    = bus.cpu_din[CIAB_LANE*8 +: 8];
          state_n = ST_SYNC;
        end
      end
      // Waiting for the last E-low slot keeps every access a full high phase.
      ST_SYNC: begin
        if (phase_sync) state_n = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (phase_strobe) begin
          aen_a_n = sel_q[CIAA_LANE];
          aen_b_n = sel_q[CIAB_LANE];
          rd_n    = rnw_q;
          wr_n    = ~rnw_q;
        end
        if (phase_last) begin
          aen_a_n = 1'b0;
          aen_b_n = 1'b0;
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          if (rnw_q) begin
            dout_n[CIAA_LANE*8 +: 8] = sel_q[CIAA_LANE] ? bus.ciaa_rdata : 8'hFF;
            dout_n[CIAB_LANE*8 +: 8] = sel_q[CIAB_LANE] ? bus.ciab_rdata : 8'hFF;
          end
          ack_n   = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        ack_n   = 1'b0;
        state_n = bus.cpu_req ? ST_RELEASE : ST_IDLE;
      end
      ST_RELEASE: begin
        if (!bus.cpu_req) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      rnw_q   <= 1'b0;
      sel_q   <= 2'b00;
      rs_q    <= 4'd0;
      wa_q    <= 8'd0;
      wb_q    <= 8'd0;
      aen_a_q <= 1'b0;
      aen_b_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      dout_q  <= 16'hFFFF;
    end else if (clk7_en) begin
      state   <= state_n;
      rnw_q   <= rnw_n;
      sel_q   <= sel_n;
      rs_q    <= rs_n;
      wa_q    <= wa_n;
      wb_q    <= wb_n;
      aen_a_q <= aen_a_n;
      aen_b_q <= aen_b_n;
      rd_q    <= rd_n;
      wr_q    <= wr_n;
      ack_q   <= ack_n;
      dout_q  <= dout_n;
    end
  end

  assign bus.cpu_dout   = dout_q;
  assign bus.cpu_ack    = ack_q;
  assign bus.eclk       = eclk;
  assign bus.cia_rs     = rs_q;
  assign bus.cia_rd     = rd_q;
  assign bus.cia_wr     = wr_q;
  assign bus.ciaa_aen   = aen_a_q;
  assign bus.ciab_aen   = aen_b_q;
  assign bus.ciaa_wdata = wa_q;
  assign bus.ciab_wdata = wb_q;

  assign dbg.state = state;
  assign dbg.ecnt  = ecnt;

endmodule

// File: tb/tb_cia_bus_initiator.sv
// Bench for cia_bus_initiator: access table with a read-data scoreboard plus hold, early-drop and reset sequences.
module tb_cia_bus_initiator;
  import cia_bus_pkg::*;

  typedef struct {
    logic        rnw;
    logic [1:0]  sel;
    logic [3:0]  rs;
    logic [15:0] din;
    logic [7:0]  a_rd;
    logic [7:0]  b_rd;
    int          start;
    logic [15:0] exp_dout;
    int          lat;
  } vec_t;

  logic     clk = 1'b0;
  logic     reset;
  logic     clk7_en;
  cia_dbg_t dbg;
  cia_bus_if bus();

  cia_bus_initiator dut (
    .clk     (clk),
    .reset   (reset),
    .clk7_en (clk7_en),
    .bus     (bus),
    .dbg     (dbg)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_err  = 0;
  int          m_ecnt = 0;
  logic [15:0] exp_q[$];
  vec_t        vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clk7_en period, followed by 0..2 disabled clocks during which nothing may move.
  task automatic tick();
    int          n_idle;
    logic [22:0] snap;
    @(negedge clk);
    clk7_en = 1'b1;
    @(posedge clk);
    #1;
    clk7_en = 1'b0;
    m_ecnt = (m_ecnt == 9) ? 0 : m_ecnt + 1;
    check("eclk", 32'(bus.eclk), 32'(m_ecnt >= 6));
    check("ecnt", 32'(dbg.ecnt), 32'(m_ecnt));
    n_idle = $urandom_range(0, 2);
    if (n_idle > 0) begin
      snap = {bus.eclk, bus.cpu_ack, bus.cpu_dout, bus.cia_rd, bus.cia_wr, dbg.state};
      repeat (n_idle) @(posedge clk);
      #1;
      check("hold_when_disabled",
            32'({bus.eclk, bus.cpu_ack, bus.cpu_dout, bus.cia_rd, bus.cia_wr, dbg.state}), 32'(snap));
    end
  endtask

  task automatic run_access(input vec_t v, input bit hold, input bit drop_early);
    int guard = 0;
    int k = 1;
    bit got = 1'b0;
    int cnt_a = 0, cnt_b = 0, cnt_rd = 0, cnt_wr = 0, bad_pos = 0, extra = 0;
    bus.ciaa_rdata = v.a_rd;
    bus.ciab_rdata = v.b_rd;
    while (m_ecnt != v.start && guard < 20) begin
      tick();
      guard++;
    end
    bus.cpu_rnw = v.rnw;
    bus.cpu_sel = v.sel;
    bus.cpu_rs  = v.rs;
    bus.cpu_din = v.din;
    bus.cpu_req = 1'b1;
    tick();
    exp_q.push_back(v.exp_dout);
    check("accept_state", 32'(dbg.state), 32'(ST_SYNC));
    check("latch_rs", 32'(bus.cia_rs), 32'(v.rs));
    check("latch_wdata", 32'({bus.ciab_wdata, bus.ciaa_wdata}), 32'(v.din));
    // Scramble the request fields: the latched copies must not follow.
    bus.cpu_din = 16'($urandom);
    bus.cpu_rs  = ~v.rs;
    bus.cpu_rnw = ~v.rnw;
    bus.cpu_sel = ~v.sel;
    if (drop_early) bus.cpu_req = 1'b0;
    while (!got && k <= 30) begin
      if (bus.ciaa_aen) cnt_a++;
      if (bus.ciab_aen) cnt_b++;
      if (bus.cia_rd) cnt_rd++;
      if (bus.cia_wr) cnt_wr++;
      if ((bus.ciaa_aen || bus.ciab_aen || bus.cia_rd || bus.cia_wr) && m_ecnt != 9) bad_pos++;
      if (bus.cpu_ack) begin
        got = 1'b1;
      end else begin
        tick();
        k++;
      end
    end
    if (!got) begin
      check("ack_timeout", 32'(0), 32'(1));
      void'(exp_q.pop_front());
    end else begin
      check("ack_latency", 32'(k), 32'(v.lat));
      check("read_data", 32'(bus.cpu_dout), 32'(exp_q.pop_front()));
      check("aen_a_count", 32'(cnt_a), 32'(v.sel[0]));
      check("aen_b_count", 32'(cnt_b), 32'(v.sel[1]));
      check("rd_count", 32'(cnt_rd), 32'(v.rnw));
      check("wr_count", 32'(cnt_wr), 32'(!v.rnw));
      check("strobe_phase", 32'(bad_pos), 32'(0));
      check("wdata_stable", 32'({bus.ciab_wdata, bus.ciaa_wdata}), 32'(v.din));
      check("rs_stable", 32'(bus.cia_rs), 32'(v.rs));
    end
    if (hold) begin
      repeat (25) begin
        tick();
        if (bus.ciaa_aen || bus.ciab_aen || bus.cia_rd || bus.cia_wr || bus.cpu_ack) extra++;
      end
      check("release_no_second_access", 32'(extra), 32'(0));
      check("release_state", 32'(dbg.state), 32'(ST_RELEASE));
    end
    bus.cpu_req = 1'b0;
    tick();
    check("back_to_idle", 32'(dbg.state), 32'(ST_IDLE));
    check("ack_one_period", 32'(bus.cpu_ack), 32'(0));
  endtask

  initial begin
    int guard;
    int idle_strobes;
    //          rnw   sel    rs    din       a_rd   b_rd  start exp_dout lat
    vecs[0] = '{1'b1, 2'b01, 4'hD, 16'h0000, 8'h82, 8'h77, 0, 16'hFF82, 10};
    vecs[1] = '{1'b0, 2'b10, 4'h5, 16'h3C00, 8'h00, 8'h00, 7, 16'hFF82, 13};
    vecs[2] = '{1'b1, 2'b11, 4'h1, 16'h0000, 8'hA5, 8'h5A, 3, 16'h5AA5, 7};
    vecs[3] = '{1'b1, 2'b00, 4'hE, 16'h0000, 8'h12, 8'h34, 9, 16'hFFFF, 11};
    vecs[4] = '{1'b0, 2'b11, 4'h8, 16'h1234, 8'h00, 8'h00, 5, 16'hFFFF, 15};
    vecs[5] = '{1'b1, 2'b10, 4'hF, 16'h0000, 8'h11, 8'hC3, 4, 16'hC3FF, 6};
    vecs[6] = '{1'b1, 2'b01, 4'h2, 16'h0000, 8'h3E, 8'h99, 2, 16'hFF3E, 8};
    vecs[7] = '{1'b0, 2'b01, 4'h6, 16'h00AB, 8'h00, 8'h00, 6, 16'hFF3E, 14};
    vecs[8] = '{1'b1, 2'b11, 4'h4, 16'h0000, 8'h01, 8'h02, 8, 16'h0201, 12};
    vecs[9] = '{1'b1, 2'b01, 4'hB, 16'h0000, 8'h55, 8'hAA, 0, 16'hFF55, 10};

    reset = 1'b1;
    clk7_en = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_rnw = 1'b0;
    bus.cpu_sel = 2'b00;
    bus.cpu_rs = 4'd0;
    bus.cpu_din = 16'd0;
    bus.ciaa_rdata = 8'hFF;
    bus.ciab_rdata = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(dbg.state), 32'(ST_IDLE));
    check("rst_ecnt_eclk", 32'({dbg.ecnt, bus.eclk}), 32'(0));
    check("rst_dout", 32'(bus.cpu_dout), 32'(16'hFFFF));
    check("rst_strobes", 32'({bus.ciaa_aen, bus.ciab_aen, bus.cia_rd, bus.cia_wr, bus.cpu_ack}), 32'(0));
    check("rst_rs_wdata", 32'({bus.cia_rs, bus.ciab_wdata, bus.ciaa_wdata}), 32'(0));
    reset = 1'b0;
    m_ecnt = 0;

    idle_strobes = 0;
    repeat (20) begin
      tick();
      if (bus.ciaa_aen || bus.ciab_aen || bus.cia_rd || bus.cia_wr || bus.cpu_ack) idle_strobes++;
    end
    check("free_run_strobes", 32'(idle_strobes), 32'(0));
    check("free_run_dout", 32'(bus.cpu_dout), 32'(16'hFFFF));

    for (int i = 0; i < 6; i++) run_access(vecs[i], 1'b0, 1'b0);

    run_access(vecs[6], 1'b1, 1'b0);
    run_access(vecs[7], 1'b0, 1'b0);
    run_access(vecs[8], 1'b0, 1'b1);

    // Write to CIA-B, then pull reset while the write strobe is up.
    bus.cpu_rnw = 1'b0;
    bus.cpu_sel = 2'b10;
    bus.cpu_rs  = 4'h5;
    bus.cpu_din = 16'h3C00;
    bus.cpu_req = 1'b1;
    guard = 0;
    while (!bus.cia_wr && guard < 40) begin
      tick();
      guard++;
    end
    check("wr_reached", 32'({bus.cia_wr, bus.ciab_aen}), 32'(2'b11));
    check("wr_phase", 32'(m_ecnt), 32'(9));
    check("wr_wdata", 32'(bus.ciab_wdata), 32'(8'h3C));
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_strobes", 32'({bus.cia_wr, bus.ciab_aen, bus.ciaa_aen, bus.cia_rd}), 32'(0));
    check("async_rst_ack", 32'(bus.cpu_ack), 32'(0));
    check("async_rst_state", 32'(dbg.state), 32'(ST_IDLE));
    bus.cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_ecnt = 0;
    run_access(vecs[9], 1'b0, 1'b0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
